// File: rtl/mac_accumulate_stage.sv
// Multiply-accumulate stage: sums NrOfTerms pixel*weight products, adds bias,
// saturates, and strobes the result into a downstream Tick-gated register.
module mac_accumulate_stage #(
    parameter int DataBits  = 8,
    parameter int AccBits   = 24,
    parameter int NrOfTerms = 784
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                Start,
    input  logic                InValid,
    input  logic [DataBits-1:0] Pixel,
    input  logic [DataBits-1:0] Weight,
    input  logic [AccBits-1:0]  Bias,
    output logic                InReady,
    output logic [AccBits-1:0]  D,
    output logic                ClockEnable,
    output logic                Busy,
    output logic                Done,
    output logic                Overflow
);

    localparam int CntBits  = (NrOfTerms > 1) ? $clog2(NrOfTerms) : 1;
    localparam int ProdBits = 2 * DataBits + 1;
    localparam int ExtBits  = AccBits + 1 - ProdBits;

    localparam logic [CntBits-1:0] LastTerm = CntBits'(NrOfTerms - 1);
    localparam logic [CntBits-1:0] CntOne   = CntBits'(1);
    localparam logic [AccBits-1:0] MaxAcc   = {1'b0, {(AccBits-1){1'b1}}};
    localparam logic [AccBits-1:0] MinAcc   = {1'b1, {(AccBits-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WRITE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [AccBits-1:0]  acc_q;
    logic [AccBits-1:0]  d_q;
    logic [CntBits-1:0]  cnt_q;
    logic                ovf_q;

    logic signed [ProdBits-1:0] pix_ext;
    logic signed [ProdBits-1:0] wt_ext;
    logic signed [ProdBits-1:0] product;
    logic        [AccBits:0]    acc_sum;
    logic        [AccBits:0]    res_sum;
    logic        [AccBits-1:0]  acc_sat;
    logic        [AccBits-1:0]  res_sat;
    logic                       acc_clamp;
    logic                       res_clamp;
    logic                       last_term;

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign pix_ext = {{DataBits{1'b0}}, 1'b0, Pixel};
    assign wt_ext  = {{(DataBits+1){Weight[DataBits-1]}}, Weight};
    assign product = pix_ext * wt_ext;

    assign acc_sum = {acc_q[AccBits-1], acc_q}
                   + {{ExtBits{product[ProdBits-1]}}, product};
    assign res_sum = {acc_q[AccBits-1], acc_q}
                   + {Bias[AccBits-1], Bias};

    // One guard bit: a clamp is needed when it disagrees with the sign bit.
    assign acc_clamp = acc_sum[AccBits] ^ acc_sum[AccBits-1];
    assign res_clamp = res_sum[AccBits] ^ res_sum[AccBits-1];

    assign acc_sat = !acc_clamp ? acc_sum[AccBits-1:0]
                   : (acc_sum[AccBits] ? MinAcc : MaxAcc);
    assign res_sat = !res_clamp ? res_sum[AccBits-1:0]
                   : (res_sum[AccBits] ? MinAcc : MaxAcc);

    assign last_term = (cnt_q == LastTerm);

    always_comb begin
        state_nxt = state;
        if (Tick) begin
            unique case (state)
                IDLE:  if (Start) state_nxt = ACCUM;
                ACCUM: if (InValid && last_term) state_nxt = WRITE;
                WRITE: state_nxt = DONE;
                DONE:  state_nxt = IDLE;
            endcase
        end
    end

    // Strobes are decoded from state, so they stretch across Tick=0 cycles.
    assign InReady     = (state == ACCUM);
    assign Busy        = (state == ACCUM) || (state == WRITE);
    assign ClockEnable = (state == WRITE);
    assign Done        = (state == DONE);
    assign D           = ClockEnable ? res_sat : d_q;
    assign Overflow    = ovf_q | (ClockEnable & res_clamp);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            d_q   <= '0;
        end else begin
            state <= state_nxt;
            if (Tick) begin
                unique case (state)
                    IDLE: begin
                        if (Start) begin
                            acc_q <= '0;
                            cnt_q <= '0;
                            ovf_q <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        if (InValid) begin
                            acc_q <= acc_sat;
                            ovf_q <= ovf_q | acc_clamp;
                            cnt_q <= last_term ? '0 : cnt_q + CntOne;
                        end
                    end
                    WRITE: begin
                        d_q   <= res_sat;
                        ovf_q <= ovf_q | res_clamp;
                    end
                    DONE: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Bench for mac_accumulate_stage: vector table, random jobs vs a
// saturating-sum model, reset abort, long saturation and single-term runs.
module tb_mac_accumulate_stage;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Tick = 1'b0;
    logic        Start = 1'b0;
    logic        Start_s = 1'b0;
    logic        Start_1 = 1'b0;
    logic        InValid = 1'b0;
    logic [7:0]  Pixel = '0;
    logic [7:0]  Weight = '0;
    logic [23:0] Bias = '0;
    logic [17:0] Bias_s = '0;
    logic [23:0] Bias_1 = '0;

    logic        InReady, ClockEnable, Busy, Done, Overflow;
    logic [23:0] D;
    logic        InReady_s, ClockEnable_s, Busy_s, Done_s, Overflow_s;
    logic [17:0] D_s;
    logic        InReady_1, ClockEnable_1, Busy_1, Done_1, Overflow_1;
    logic [23:0] D_1;

    mac_accumulate_stage #(
        .DataBits(8), .AccBits(24), .NrOfTerms(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .Start(Start), .InValid(InValid),
        .Pixel(Pixel), .Weight(Weight), .Bias(Bias),
        .InReady(InReady), .D(D), .ClockEnable(ClockEnable),
        .Busy(Busy), .Done(Done), .Overflow(Overflow)
    );

    mac_accumulate_stage #(
        .DataBits(8), .AccBits(18), .NrOfTerms(784)
    ) dut_sat (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .Start(Start_s), .InValid(InValid),
        .Pixel(Pixel), .Weight(Weight), .Bias(Bias_s),
        .InReady(InReady_s), .D(D_s), .ClockEnable(ClockEnable_s),
        .Busy(Busy_s), .Done(Done_s), .Overflow(Overflow_s)
    );

    mac_accumulate_stage #(
        .DataBits(8), .AccBits(24), .NrOfTerms(1)
    ) dut_one (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .Start(Start_1), .InValid(InValid),
        .Pixel(Pixel), .Weight(Weight), .Bias(Bias_1),
        .InReady(InReady_1), .D(D_1), .ClockEnable(ClockEnable_1),
        .Busy(Busy_1), .Done(Done_1), .Overflow(Overflow_1)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0][7:0] pix;
        logic [3:0][7:0] wt;
        logic [23:0]     bias;
        logic [1:0]      tmode;
        logic            gaps;
        logic [23:0]     d;
        logic            ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int tick_mode = 0;

    // Downstream view: what a Tick-gated register would actually capture.
    int          ce_t = 0;
    int          ce_c = 0;
    int          done_t = 0;
    logic [23:0] cap_d = '0;
    logic        cap_ovf = 1'b0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ce_t = 0;
            ce_c = 0;
            done_t = 0;
        end else begin
            if (ClockEnable) ce_c = ce_c + 1;
            if (ClockEnable && Tick) begin
                ce_t = ce_t + 1;
                cap_d = D;
                cap_ovf = Overflow;
            end
            if (Done && Tick) done_t = done_t + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        cyc_n++;
        case (tick_mode)
            0: Tick = 1'b1;
            1: Tick = (cyc_n % 3 == 0);
            default: Tick = 1'($urandom_range(0, 1));
        endcase
    endtask

    function automatic vec_t mk(input int p0, p1, p2, p3,
                                input int w0, w1, w2, w3,
                                input int bias, tm, gp, d, ov);
        vec_t v;
        v.pix[0] = 8'(p0); v.pix[1] = 8'(p1);
        v.pix[2] = 8'(p2); v.pix[3] = 8'(p3);
        v.wt[0] = 8'(w0); v.wt[1] = 8'(w1);
        v.wt[2] = 8'(w2); v.wt[3] = 8'(w3);
        v.bias = 24'(bias);
        v.tmode = 2'(tm);
        v.gaps = 1'(gp);
        v.d = 24'(d);
        v.ovf = 1'(ov);
        return v;
    endfunction

    // Sum of signed products, clamped after every term, then plus bias.
    function automatic void model(input vec_t v, output logic [23:0] d,
                                  output logic ovf);
        longint mx = 64'sd8388607;
        longint mn = -64'sd8388608;
        longint acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc += longint'(v.pix[i]) * longint'($signed(v.wt[i]));
            if (acc > mx) begin acc = mx; ovf = 1'b1; end
            if (acc < mn) begin acc = mn; ovf = 1'b1; end
        end
        acc += longint'($signed(v.bias));
        if (acc > mx) begin acc = mx; ovf = 1'b1; end
        if (acc < mn) begin acc = mn; ovf = 1'b1; end
        d = 24'(acc);
    endfunction

    task automatic run_job(input string name, input vec_t v);
        int  n;
        int  c0, cc0, d0;
        bit  acc;
        tick_mode = int'(v.tmode);
        c0 = ce_t; cc0 = ce_c; d0 = done_t;
        Bias = v.bias;
        // A pair offered in IDLE must be discarded.
        Pixel = 8'd200; Weight = 8'd100; InValid = 1'b1;
        Start = 1'b1;
        n = 0;
        while (!Tick && n < 50) begin step(); n++; end
        step();
        Start = 1'b0;
        chk({name, "_busy"}, 64'(Busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (v.gaps && i > 0) begin
                InValid = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    Start = (k == 2);
                    step();
                end
                Start = 1'b0;
            end
            Pixel = v.pix[i]; Weight = v.wt[i]; InValid = 1'b1;
            acc = 1'b0; n = 0;
            while (!acc && n < 100) begin
                acc = InReady && Tick;
                step();
                n++;
            end
            if (!acc) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
        end
        // Pairs offered in WRITE/DONE must be discarded too.
        Pixel = 8'd255; Weight = 8'd127;
        n = 0;
        while (done_t == d0 && n < 100) begin step(); n++; end
        InValid = 1'b0;
        chk({name, "_ce_ticks"}, 64'(ce_t - c0), 64'd1);
        chk({name, "_done_ticks"}, 64'(done_t - d0), 64'd1);
        chk({name, "_d"}, 64'(cap_d), 64'(v.d));
        chk({name, "_ovf"}, 64'(cap_ovf), 64'(v.ovf));
        chk({name, "_d_hold"}, 64'(D), 64'(v.d));
        chk({name, "_idle"}, 64'(Busy), 64'd0);
        if (v.tmode == 2'd1)
            chk({name, "_ce_window"}, 64'(ce_c - cc0), 64'd3);
    endtask

    vec_t        vt[7];
    vec_t        rv;
    logic [23:0] ed;
    logic        eo;
    int          n;

    initial begin
        vt[0] = mk(10, 20, 5, 1, 3, -2, 7, -1, 100, 0, 0, 124, 0);
        vt[1] = mk(10, 20, 5, 1, 3, -2, 7, -1, 100, 1, 0, 124, 0);
        vt[2] = mk(10, 20, 5, 1, 3, -2, 7, -1, 100, 0, 1, 124, 0);
        vt[3] = mk(10, 20, 5, 1, 3, -2, 7, -1, 100, 2, 1, 124, 0);
        vt[4] = mk(255, 255, 255, 255, 127, 127, 127, 127,
                   8388607, 0, 0, 8388607, 1);
        vt[5] = mk(255, 255, 255, 255, -128, -128, -128, -128,
                   -8388608, 0, 0, -8388608, 1);
        vt[6] = mk(0, 255, 128, 7, -128, -1, 1, 7, -5, 1, 0, -83, 0);

        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_d", 64'(D), 64'd0);
        chk("rst_ce", 64'(ClockEnable), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_job($sformatf("vec%0d", i), vt[i]);

        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) begin
                rv.pix[i] = 8'($urandom);
                rv.wt[i] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) rv.bias = 24'($urandom);
            else rv.bias = 24'($signed(12'($urandom)));
            rv.tmode = 2'($urandom_range(0, 2));
            rv.gaps = 1'($urandom_range(0, 1));
            model(rv, ed, eo);
            rv.d = ed;
            rv.ovf = eo;
            run_job($sformatf("rnd%0d", j), rv);
        end

        // Reset in the middle of an accumulation, then a fresh job.
        tick_mode = 0;
        Tick = 1'b1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        Pixel = 8'd50; Weight = 8'd50; InValid = 1'b1;
        step();
        step();
        InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_inready", 64'(InReady), 64'd0);
        chk("abort_ce", 64'(ClockEnable), 64'd0);
        chk("abort_d", 64'(D), 64'd0);
        chk("abort_ovf", 64'(Overflow), 64'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step();
        run_job("after_rst", mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 4, 0));
        chk("after_rst_ce_total", 64'(ce_t), 64'd1);

        // Long run on the narrow accumulator forces saturation.
        tick_mode = 0;
        Tick = 1'b1;
        Bias_s = '0;
        Start_s = 1'b1;
        step();
        Start_s = 1'b0;
        Pixel = 8'd255; Weight = 8'd127; InValid = 1'b1;
        n = 0;
        while (!ClockEnable_s && n < 900) begin step(); n++; end
        chk("sat_len", 64'(n), 64'd784);
        chk("sat_d", 64'(D_s), 64'h1FFFF);
        chk("sat_ovf", 64'(Overflow_s), 64'd1);
        InValid = 1'b0;
        step();
        chk("sat_done", 64'(Done_s), 64'd1);
        step();

        // Single-term configuration: WRITE two edges after Start.
        Bias_1 = 24'hFFFFFB;
        Start_1 = 1'b1;
        step();
        Start_1 = 1'b0;
        chk("one_inready", 64'(InReady_1), 64'd1);
        Pixel = 8'd0; Weight = 8'h80; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk("one_ce", 64'(ClockEnable_1), 64'd1);
        chk("one_d", 64'(D_1), 64'hFFFFFB);
        chk("one_ovf", 64'(Overflow_1), 64'd0);
        step();
        chk("one_done", 64'(Done_1), 64'd1);
        chk("one_ce_off", 64'(ClockEnable_1), 64'd0);
        step();
        chk("one_done_off", 64'(Done_1), 64'd0);
        chk("one_d_hold", 64'(D_1), 64'hFFFFFB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
